// File: rtl/psram_pkg.sv
// Shared PSRAM constants plus read-capture defaults and the FIFO level-width helper.
package psram_pkg;

   localparam logic [7:0] PSRAM_CMD_SYNC_READ  = 8'h00;
   localparam logic [7:0] PSRAM_CMD_SYNC_WRITE = 8'h80;
   localparam logic [7:0] PSRAM_CMD_REG_READ   = 8'h40;
   localparam logic [7:0] PSRAM_CMD_REG_WRITE  = 8'hC0;
   localparam logic [7:0] PSRAM_CMD_RESET      = 8'hFF;

   localparam int PSRAM_RDCAP_FIFO_DEPTH  = 8;
   localparam int PSRAM_RDCAP_SYNC_STAGES = 2;

   // Occupancy must be able to represent DEPTH itself, hence the extra bit.
   function automatic int rdcap_level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/psram_rdcap_fifo.sv
// Synchronous first-word-fall-through byte FIFO with flush; reports accepted and dropped pushes.
module psram_rdcap_fifo
   import psram_pkg::*;
#(
   parameter int DEPTH = PSRAM_RDCAP_FIFO_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clr,
   input  logic                            push,
   input  logic [7:0]                      push_data,
   input  logic                            pop,
   output logic [7:0]                      head,
   output logic [rdcap_level_w(DEPTH)-1:0] level,
   output logic                            full,
   output logic                            empty,
   output logic                            accepted,
   output logic                            dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = rdcap_level_w(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);

   // A pop frees the slot in the same cycle, so a push at full is still legal alongside one.
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign accepted = do_push & ~clr;
   assign dropped  = push & ~do_push & ~clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (accepted) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign level = count;

endmodule

// File: rtl/psram_rdcap.sv
// PSRAM OPI read-data capture: synchronises DQS/IO, pushes a byte on every DQS edge while enabled.
// Optional captured-byte counter enabled by defining PSRAM_RDCAP_BCNT_EN.
module psram_rdcap
   import psram_pkg::*;
#(
   parameter int FIFO_DEPTH  = PSRAM_RDCAP_FIFO_DEPTH,
   parameter int SYNC_STAGES = PSRAM_RDCAP_SYNC_STAGES
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 en_i,
   input  logic                                 clr_i,
   input  logic                                 psram_dqs_in_i,
   input  logic [7:0]                           psram_io_in_i,
   output logic                                 rd_valid_o,
   output logic [7:0]                           rd_data_o,
   input  logic                                 rd_ready_i,
   output logic                                 full_o,
   output logic                                 empty_o,
   output logic [rdcap_level_w(FIFO_DEPTH)-1:0] level_o,
   output logic                                 ovf_o,
   output logic [15:0]                          bcnt_o
);

   logic [SYNC_STAGES-1:0] dqs_sync;
   logic [7:0]             io_sync [SYNC_STAGES];
   logic                   dqs_hist;
   logic                   dqs_edge;
   logic                   push;
   logic                   accepted;
   logic                   dropped;
   logic                   ovf_reg;

   // Data rides an identical chain so the byte seen at the last stage matches the strobe edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dqs_sync <= '0;
         dqs_hist <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) io_sync[i] <= '0;
      end else begin
         dqs_sync   <= {dqs_sync[SYNC_STAGES-2:0], psram_dqs_in_i};
         dqs_hist   <= dqs_sync[SYNC_STAGES-1];
         io_sync[0] <= psram_io_in_i;
         for (int i = 1; i < SYNC_STAGES; i++) io_sync[i] <= io_sync[i-1];
      end
   end

   // History tracks DQS even when disabled, so raising en_i never produces a stale edge.
   assign dqs_edge = dqs_sync[SYNC_STAGES-1] ^ dqs_hist;
   assign push     = dqs_edge & en_i;

   psram_rdcap_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .clr       (clr_i),
      .push      (push),
      .push_data (io_sync[SYNC_STAGES-1]),
      .pop       (rd_ready_i),
      .head      (rd_data_o),
      .level     (level_o),
      .full      (full_o),
      .empty     (empty_o),
      .accepted  (accepted),
      .dropped   (dropped)
   );

   assign rd_valid_o = ~empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        ovf_reg <= 1'b0;
      else if (clr_i)   ovf_reg <= 1'b0;
      else if (dropped) ovf_reg <= 1'b1;
   end

   assign ovf_o = ovf_reg;

`ifdef PSRAM_RDCAP_BCNT_EN
   logic [15:0] bcnt_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         bcnt_reg <= '0;
      else if (clr_i)    bcnt_reg <= '0;
      else if (accepted) bcnt_reg <= bcnt_reg + 16'd1;
   end

   assign bcnt_o = bcnt_reg;
`else
   assign bcnt_o = '0;
`endif

endmodule

// File: tb/tb_psram_rdcap.sv
// Directed bench for psram_rdcap (default FIFO_DEPTH=8, SYNC_STAGES=2).
module tb_psram_rdcap;

   logic       clk_i;
   logic       rst_i;
   logic       en_i;
   logic       clr_i;
   logic       psram_dqs_in_i;
   logic [7:0] psram_io_in_i;
   logic       rd_valid_o;
   logic [7:0] rd_data_o;
   logic       rd_ready_i;
   logic       full_o;
   logic       empty_o;
   logic [3:0] level_o;
   logic       ovf_o;
   logic [15:0] bcnt_o;

   int n_cmp = 0;
   int n_err = 0;
   int exp_bcnt = 0;
   logic [7:0] ddr_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

   psram_rdcap #(
      .FIFO_DEPTH  (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .clr_i          (clr_i),
      .psram_dqs_in_i (psram_dqs_in_i),
      .psram_io_in_i  (psram_io_in_i),
      .rd_valid_o     (rd_valid_o),
      .rd_data_o      (rd_data_o),
      .rd_ready_i     (rd_ready_i),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .level_o        (level_o),
      .ovf_o          (ovf_o),
      .bcnt_o         (bcnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bexp();
`ifdef PSRAM_RDCAP_BCNT_EN
      return 32'(exp_bcnt & 16'hFFFF);
`else
      return 32'd0;
`endif
   endfunction

   // Toggle DQS with a new byte; level must hold for 2 cycles and move on the 3rd.
   task automatic toggle(input string tag, input logic [7:0] b, input logic expect_push);
      logic [3:0] prev;
      prev = level_o;
      psram_io_in_i  = b;
      psram_dqs_in_i = ~psram_dqs_in_i;
      step();
      step();
      check({tag, "_hold"}, 32'(level_o), 32'(prev));
      step();
      check({tag, "_push"}, 32'(level_o), 32'(prev) + 32'(expect_push));
      if (expect_push) exp_bcnt++;
   endtask

   task automatic pop_check(input string tag, input logic [7:0] b);
      check({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
      check({tag, "_data"}, 32'(rd_data_o), 32'(b));
      rd_ready_i = 1'b1;
      step();
      rd_ready_i = 1'b0;
   endtask

   initial begin
      rst_i          = 1'b1;
      en_i           = 1'b0;
      clr_i          = 1'b0;
      psram_dqs_in_i = 1'b0;
      psram_io_in_i  = 8'h00;
      rd_ready_i     = 1'b0;
      #12;
      check("rst_level", 32'(level_o), 32'd0);
      check("rst_empty", 32'(empty_o), 32'd1);
      check("rst_full", 32'(full_o), 32'd0);
      check("rst_valid", 32'(rd_valid_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
      check("rst_bcnt", 32'(bcnt_o), 32'd0);
      step();
      rst_i = 1'b0;
      step();

      // DDR capture of four bytes
      en_i = 1'b1;
      for (int i = 0; i < 4; i++) toggle("ddr", ddr_bytes[i], 1'b1);
      $display("ddr capture: level=%0d bcnt=%0d", level_o, bcnt_o);
      check("ddr_bcnt", 32'(bcnt_o), bexp());
      for (int i = 0; i < 4; i++) pop_check("ddr_pop", ddr_bytes[i]);
      check("ddr_empty", 32'(empty_o), 32'd1);

      // Gating: edges while disabled, then enable with DQS static
      en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         psram_io_in_i  = 8'h50 + 8'(i);
         psram_dqs_in_i = ~psram_dqs_in_i;
         step();
      end
      repeat (4) step();
      en_i = 1'b1;
      repeat (5) step();
      $display("gating: level=%0d", level_o);
      check("gate_level", 32'(level_o), 32'd0);

      // Overflow: 10 edges, no reads
      for (int i = 0; i < 10; i++) toggle("ovf", 8'h10 + 8'(i), i < 8);
      $display("overflow: level=%0d full=%0d ovf=%0d bcnt=%0d", level_o, full_o, ovf_o, bcnt_o);
      check("ovf_full", 32'(full_o), 32'd1);
      check("ovf_flag", 32'(ovf_o), 32'd1);
      check("ovf_level", 32'(level_o), 32'd8);
      check("ovf_bcnt", 32'(bcnt_o), bexp());
      for (int i = 0; i < 8; i++) pop_check("ovf_pop", 8'h10 + 8'(i));
      check("ovf_drain_empty", 32'(empty_o), 32'd1);
      check("ovf_sticky", 32'(ovf_o), 32'd1);
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      exp_bcnt = 0;
      check("clr_ovf", 32'(ovf_o), 32'd0);
      check("clr_bcnt", 32'(bcnt_o), bexp());

      // Simultaneous push and pop at full
      for (int i = 0; i < 8; i++) toggle("fill", 8'h20 + 8'(i), 1'b1);
      check("fill_full", 32'(full_o), 32'd1);
      psram_io_in_i  = 8'h28;
      psram_dqs_in_i = ~psram_dqs_in_i;
      step();
      step();
      rd_ready_i = 1'b1;
      step();
      rd_ready_i = 1'b0;
      exp_bcnt++;
      $display("push+pop at full: level=%0d ovf=%0d head=%0h", level_o, ovf_o, rd_data_o);
      check("pp_level", 32'(level_o), 32'd8);
      check("pp_ovf", 32'(ovf_o), 32'd0);
      check("pp_full", 32'(full_o), 32'd1);
      check("pp_head", 32'(rd_data_o), 32'h21);
      check("pp_bcnt", 32'(bcnt_o), bexp());

      // clr_i wins over a same-cycle push into a level-5 FIFO
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      exp_bcnt = 0;
      for (int i = 0; i < 5; i++) toggle("lvl5", 8'h30 + 8'(i), 1'b1);
      check("lvl5_level", 32'(level_o), 32'd5);
      psram_io_in_i  = 8'h35;
      psram_dqs_in_i = ~psram_dqs_in_i;
      step();
      step();
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      exp_bcnt = 0;
      $display("clr priority: level=%0d ovf=%0d", level_o, ovf_o);
      check("clrp_level", 32'(level_o), 32'd0);
      check("clrp_ovf", 32'(ovf_o), 32'd0);
      check("clrp_empty", 32'(empty_o), 32'd1);
      check("clrp_bcnt", 32'(bcnt_o), bexp());
      repeat (3) step();
      check("clrp_settle", 32'(level_o), 32'd0);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 3; i++) toggle("burst", 8'h40 + 8'(i), 1'b1);
      psram_io_in_i  = 8'h43;
      psram_dqs_in_i = ~psram_dqs_in_i;
      step();
      rst_i = 1'b1;
      #2;
      exp_bcnt = 0;
      $display("mid-burst reset: level=%0d empty=%0d", level_o, empty_o);
      check("mrst_level", 32'(level_o), 32'd0);
      check("mrst_empty", 32'(empty_o), 32'd1);
      check("mrst_valid", 32'(rd_valid_o), 32'd0);
      check("mrst_ovf", 32'(ovf_o), 32'd0);
      check("mrst_bcnt", 32'(bcnt_o), 32'd0);
      psram_dqs_in_i = 1'b0;
      en_i = 1'b0;
      step();
      step();
      rst_i = 1'b0;
      repeat (4) step();
      check("mrst_after", 32'(level_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
